distance_calculator: RTL and testbench

- Computes the squared Euclidean distance between one training vector and one input vector, each of M*N unsigned W-bit elements.
- Data arrives in chunks of up to MAX_ELEMENTS elements per `ready` pulse. The block requests each further chunk and reports the distance plus the training vector's class label.
- Sits upstream of the KNN sorter/classifier, one instance per training-vector comparison.

---
 rtl/knn_pkg.sv | 46 ++++
 rtl/distance_calculator_sq_abs_diff.sv | 20 ++
 rtl/distance_calculator.sv | 143 ++++++++++++++
 tb/tb_distance_calculator.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/knn_pkg.sv
// Shared types and helpers for the KNN distance datapath.
package knn_pkg;

  // Controller states of the distance calculator.
  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    REQ,
    WAIT,
    DONE
  } state_t;

  // Default configuration of the feature matrix and chunk bus.
  localparam int unsigned M_DEF      = 60;
  localparam int unsigned N_DEF      = 10;
  localparam int unsigned W_DEF      = 32;
  localparam int unsigned MAX_DEF    = 30;
  localparam int unsigned TYPE_W_DEF = 2;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Accumulator width: a 2W-bit square summed l_tot times.
  function automatic int unsigned acc_width(input int unsigned w, input int unsigned l_tot);
    return 2 * w + clog2(l_tot);
  endfunction

  localparam int unsigned ACC_W = acc_width(W_DEF, M_DEF * N_DEF);

  // Elements carried by the chunk starting at element 'consumed'.
  function automatic int unsigned chunk_len(input int unsigned consumed,
                                            input int unsigned l_tot,
                                            input int unsigned max_el);
    int unsigned rem;
    rem = (consumed < l_tot) ? (l_tot - consumed) : 0;
    return (rem < max_el) ? rem : max_el;
  endfunction

endpackage

// File: rtl/distance_calculator_sq_abs_diff.sv
// Combinational squared absolute difference of two unsigned W-bit operands.
module sq_abs_diff #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] sq
);

  logic [W-1:0]   diff;
  logic [2*W-1:0] diff_ext;

  // Subtract the smaller operand from the larger so no sign bit is needed.
  always_comb begin
    diff     = (a >= b) ? (a - b) : (b - a);
    diff_ext = {{W{1'b0}}, diff};
    sq       = diff_ext * diff_ext;
  end

endmodule

// File: rtl/distance_calculator.sv
// Squared Euclidean distance between a training vector and an input vector,
// streamed in chunks; one element is accumulated per clock.
module distance_calculator
  import knn_pkg::*;
#(
  parameter int unsigned M            = M_DEF,
  parameter int unsigned N            = N_DEF,
  parameter int unsigned W            = W_DEF,
  parameter int unsigned MAX_ELEMENTS = MAX_DEF,
  parameter int unsigned TYPE_W       = TYPE_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ready,
  input  logic [MAX_ELEMENTS*W-1:0] training_data,
  input  logic [TYPE_W-1:0]         training_data_type,
  input  logic [MAX_ELEMENTS*W-1:0] input_data,
  output logic [W-1:0]              distance,
  output logic [TYPE_W-1:0]         data_type,
  output logic                      done,
  output logic                      data_request
);

  localparam int unsigned L_TOT    = M * N;
  localparam int unsigned ACC_BITS = acc_width(W, L_TOT);
  localparam int unsigned IDX_W    = (clog2(MAX_ELEMENTS) > 0) ? clog2(MAX_ELEMENTS) : 1;
  localparam int unsigned CNT_W    = clog2(L_TOT + 1);

  state_t state, state_next;

  logic [W-1:0]        a_chunk [MAX_ELEMENTS];
  logic [W-1:0]        b_chunk [MAX_ELEMENTS];
  logic [IDX_W-1:0]    elem_idx;
  logic [CNT_W-1:0]    consumed;
  logic [ACC_BITS-1:0] acc;
  logic [TYPE_W-1:0]   type_q;

  logic                capture;
  logic [31:0]         lc;
  logic                elem_last;
  logic                final_chunk;
  logic [2*W-1:0]      sq;
  logic [ACC_BITS-1:0] acc_next;
  logic [W-1:0]        dist_sat;

  // Chunks are taken only when the controller is waiting for data.
  assign capture     = ready && ((state == IDLE) || (state == WAIT));
  assign lc          = chunk_len(32'(consumed), L_TOT, MAX_ELEMENTS);
  assign elem_last   = (32'(elem_idx) + 32'd1 == lc);
  assign final_chunk = (32'(consumed) + lc == L_TOT);

  sq_abs_diff #(.W(W)) u_sq (
    .a  (a_chunk[elem_idx]),
    .b  (b_chunk[elem_idx]),
    .sq (sq)
  );

  // Running sum including the current element, clamped to W bits for output.
  always_comb begin
    acc_next = acc + ACC_BITS'(sq);
    dist_sat = (|acc_next[ACC_BITS-1:W]) ? {W{1'b1}} : acc_next[W-1:0];
  end

  // State register.
  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state decode.
  // NOTE: state_next gets a default first so no path through the case infers a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (ready) state_next = ACCUM;
      ACCUM:   if (elem_last) state_next = final_chunk ? DONE : REQ;
      REQ:     state_next = WAIT;
      WAIT:    if (ready) state_next = ACCUM;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Chunk buffers; contents are meaningless until a capture so they carry no reset.
  // NOTE: leaving data storage unreset keeps it as plain flops or RAM without a reset tree.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int k = 0; k < int'(MAX_ELEMENTS); k++) begin
        a_chunk[k] <= training_data[k*W +: W];
        b_chunk[k] <= input_data[k*W +: W];
      end
    end
  end

  // Element counter, accumulator and registered result/handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      elem_idx     <= '0;
      consumed     <= '0;
      acc          <= '0;
      type_q       <= '0;
      distance     <= '0;
      data_type    <= '0;
      done         <= 1'b0;
      data_request <= 1'b0;
    end else begin
      done         <= 1'b0;
      data_request <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ready) begin
            elem_idx <= '0;
            consumed <= '0;
            acc      <= '0;
            type_q   <= training_data_type;
          end
        end
        WAIT: begin
          if (ready) elem_idx <= '0;
        end
        ACCUM: begin
          acc <= acc_next;
          if (elem_last) begin
            elem_idx <= '0;
            consumed <= consumed + CNT_W'(lc);
            if (final_chunk) begin
              distance  <= dist_sat;
              data_type <= type_q;
              done      <= 1'b1;
            end else begin
              data_request <= 1'b1;
            end
          end else begin
            elem_idx <= elem_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_distance_calculator.sv
// Directed self-checking bench for distance_calculator in three configurations.
module tb_distance_calculator;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  // Default configuration: 600 elements, 30 per chunk.
  logic           ready0 = 1'b0;
  logic [959:0]   td0 = '0;
  logic [959:0]   id0 = '0;
  logic [1:0]     tt0 = '0;
  logic [31:0]    dist0;
  logic [1:0]     dt0;
  logic           done0, dreq0;

  // Single partial chunk: 6 elements on a 30-element bus.
  logic           ready1 = 1'b0;
  logic [959:0]   td1 = '0;
  logic [959:0]   id1 = '0;
  logic [1:0]     tt1 = '0;
  logic [31:0]    dist1;
  logic [1:0]     dt1;
  logic           done1, dreq1;

  // Narrow configuration: W=8, 4 elements, one full chunk.
  logic           ready2 = 1'b0;
  logic [31:0]    td2 = '0;
  logic [31:0]    id2 = '0;
  logic [1:0]     tt2 = '0;
  logic [7:0]     dist2;
  logic [1:0]     dt2;
  logic           done2, dreq2;

  distance_calculator #(.M(60), .N(10), .W(32), .MAX_ELEMENTS(30), .TYPE_W(2)) dut0 (
    .clk(clk), .rst(rst), .ready(ready0), .training_data(td0),
    .training_data_type(tt0), .input_data(id0), .distance(dist0),
    .data_type(dt0), .done(done0), .data_request(dreq0)
  );

  distance_calculator #(.M(2), .N(3), .W(32), .MAX_ELEMENTS(30), .TYPE_W(2)) dut1 (
    .clk(clk), .rst(rst), .ready(ready1), .training_data(td1),
    .training_data_type(tt1), .input_data(id1), .distance(dist1),
    .data_type(dt1), .done(done1), .data_request(dreq1)
  );

  distance_calculator #(.M(1), .N(4), .W(8), .MAX_ELEMENTS(4), .TYPE_W(2)) dut2 (
    .clk(clk), .rst(rst), .ready(ready2), .training_data(td2),
    .training_data_type(tt2), .input_data(id2), .distance(dist2),
    .data_type(dt2), .done(done2), .data_request(dreq2)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] tv0 [600];
  logic [31:0] iv0 [600];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Streams tv0/iv0 into dut0 chunk by chunk, answering each data_request.
  // extra_cyc injects a stray ready during chunk 2; rst_cyc resets during chunk 2.
  task automatic run0(input bit chk_lat, input int extra_cyc, input int rst_cyc,
                      output int n_req, output bit got_done);
    int cyc;
    bit busy;
    n_req    = 0;
    got_done = 1'b0;
    busy     = 1'b1;
    for (int chunk = 0; chunk < 20 && busy; chunk++) begin
      @(negedge clk);
      for (int k = 0; k < 30; k++) begin
        td0[k*32 +: 32] = tv0[chunk*30 + k];
        id0[k*32 +: 32] = iv0[chunk*30 + k];
      end
      ready0 = 1'b1;
      cyc    = 0;
      do begin
        @(negedge clk);
        cyc++;
        ready0 = (chunk == 2) && (cyc == extra_cyc);
        if ((chunk == 2) && (cyc == rst_cyc)) begin
          #2 rst = 1'b0;
          #1;
          check("rst_distance", 64'(dist0), 64'd0);
          check("rst_data_type", 64'(dt0), 64'd0);
          check("rst_done", 64'(done0), 64'd0);
          check("rst_data_request", 64'(dreq0), 64'd0);
          @(negedge clk);
          rst  = 1'b1;
          busy = 1'b0;
        end
      end while (busy && !(dreq0 || done0) && cyc < 64);
      ready0 = 1'b0;
      if (busy) begin
        if (chk_lat) check("latency", 64'(cyc), 64'd31);
        check("pulse_exclusive", 64'(dreq0 & done0), 64'd0);
        if (done0) begin
          got_done = 1'b1;
          busy     = 1'b0;
        end else if (dreq0) begin
          n_req++;
        end else begin
          check("pulse_timeout", 64'(dreq0 | done0), 64'd1);
          busy = 1'b0;
        end
      end
    end
  endtask

  initial begin
    int          n_req;
    bit          got_done;
    int          cyc;
    int          cnt;
    longint      ref_sum;
    longint      d;
    logic [31:0] clean_dist;
    logic [31:0] t1 [6];
    logic [31:0] i1 [6];

    // Reset state.
    #12;
    check("reset_distance", 64'(dist0), 64'd0);
    check("reset_data_type", 64'(dt0), 64'd0);
    check("reset_done", 64'(done0), 64'd0);
    check("reset_data_request", 64'(dreq0), 64'd0);
    check("reset_distance_small", 64'(dist2), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Ones against zeros: 19 requests, distance 600, label 2.
    for (int i = 0; i < 600; i++) begin
      tv0[i] = 32'd1;
      iv0[i] = 32'd0;
    end
    tt0 = 2'd2;
    run0(1'b1, -1, -1, n_req, got_done);
    check("ones_requests", 64'(n_req), 64'd19);
    check("ones_done", 64'(got_done), 64'd1);
    check("ones_distance", 64'(dist0), 64'd600);
    check("ones_data_type", 64'(dt0), 64'd2);
    @(negedge clk);
    check("ones_done_one_cycle", 64'(done0), 64'd0);
    check("ones_distance_held", 64'(dist0), 64'd600);

    // Random values 0..300 with a software reference sum.
    ref_sum = 0;
    for (int i = 0; i < 600; i++) begin
      tv0[i]  = 32'($urandom_range(300, 0));
      iv0[i]  = 32'($urandom_range(300, 0));
      d       = (tv0[i] > iv0[i]) ? longint'(tv0[i] - iv0[i]) : longint'(iv0[i] - tv0[i]);
      ref_sum = ref_sum + d * d;
    end
    tt0 = 2'd3;
    run0(1'b1, -1, -1, n_req, got_done);
    check("rand_requests", 64'(n_req), 64'd19);
    check("rand_done", 64'(got_done), 64'd1);
    check("rand_distance", 64'(dist0), 64'(ref_sum));
    check("rand_data_type", 64'(dt0), 64'd3);
    clean_dist = dist0;

    // Same data with a stray ready pulse during accumulation.
    run0(1'b1, 5, -1, n_req, got_done);
    check("extra_ready_done", 64'(got_done), 64'd1);
    check("extra_ready_distance", 64'(dist0), 64'(clean_dist));

    // Reset during the third chunk: outputs cleared, no done afterwards.
    run0(1'b0, -1, 10, n_req, got_done);
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      cnt += int'(done0);
    end
    check("abort_no_done", 64'(cnt), 64'd0);
    for (int i = 0; i < 600; i++) begin
      tv0[i] = 32'd1;
      iv0[i] = 32'd0;
    end
    tt0 = 2'd2;
    run0(1'b0, -1, -1, n_req, got_done);
    check("after_reset_done", 64'(got_done), 64'd1);
    check("after_reset_distance", 64'(dist0), 64'd600);

    // Single partial chunk: no request, done 7 cycles after ready, distance 62.
    t1 = '{32'd5, 32'd0, 32'd7, 32'd1, 32'd2, 32'd3};
    i1 = '{32'd2, 32'd4, 32'd7, 32'd0, 32'd2, 32'd9};
    @(negedge clk);
    td1 = {960{1'b1}};
    id1 = '0;
    for (int k = 0; k < 6; k++) begin
      td1[k*32 +: 32] = t1[k];
      id1[k*32 +: 32] = i1[k];
    end
    tt1    = 2'd1;
    ready1 = 1'b1;
    cyc    = 0;
    cnt    = 0;
    do begin
      @(negedge clk);
      cyc++;
      ready1 = 1'b0;
      tt1    = 2'd3;
      cnt   += int'(dreq1);
    end while (!done1 && cyc < 20);
    check("single_latency", 64'(cyc), 64'd7);
    check("single_requests", 64'(cnt), 64'd0);
    check("single_distance", 64'(dist1), 64'd62);
    check("single_data_type", 64'(dt1), 64'd1);

    // W=8: 4 * 255^2 = 260100 saturates to 255.
    @(negedge clk);
    td2    = 32'hFFFF_FFFF;
    id2    = 32'h0;
    tt2    = 2'd2;
    ready2 = 1'b1;
    cyc    = 0;
    do begin
      @(negedge clk);
      cyc++;
      ready2 = 1'b0;
    end while (!done2 && cyc < 20);
    check("sat_latency", 64'(cyc), 64'd5);
    check("sat_distance", 64'(dist2), 64'd255);
    check("sat_data_type", 64'(dt2), 64'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
